// File: rtl/fifo_out_pkg.sv
// rtl/fifo_out_pkg.sv - shared widths and FSM state encodings for fifo_out_arb
package fifo_out_pkg;
   localparam int STATE_W = 3;
   localparam int DATA_W  = 8;
   localparam int CNT_W   = 16;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE   = 3'd0,
      ST_ARB    = 3'd1,
      ST_READ   = 3'd2,
      ST_LAUNCH = 3'd3,
      ST_WAIT   = 3'd4
   } state_e;
endpackage

// File: rtl/arb_rr2.sv
// rtl/arb_rr2.sv - two-channel grant selection
// FIFO_OUT_ARB_STRICT_PRIO_EN: channel 0 wins ties instead of round-robin.
module arb_rr2
   import fifo_out_pkg::*;
(
   input  logic [1:0] eligible_i,
   input  logic       last_grant_i,
   output logic       next_grant_o,
   output logic       valid_o
);

   always_comb begin
      valid_o      = |eligible_i;
      next_grant_o = last_grant_i;
      case (eligible_i)
         2'b01: next_grant_o = 1'b0;
         2'b10: next_grant_o = 1'b1;
         2'b11: begin
`ifdef FIFO_OUT_ARB_STRICT_PRIO_EN
            next_grant_o = 1'b0;
`else
            next_grant_o = ~last_grant_i;
`endif
         end
         default: next_grant_o = last_grant_i;
      endcase
   end

endmodule

// File: rtl/fifo_out_arb.sv
// rtl/fifo_out_arb.sv - arbitrates two byte FIFOs onto one shared transmitter
// FIFO_OUT_ARB_STRICT_PRIO_EN (evaluated in arb_rr2) selects strict channel-0 priority.
module fifo_out_arb
   import fifo_out_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                enable,
   input  logic                fifo0_empty,
   input  logic                fifo0_busy,
   input  logic [DATA_W-1:0]   fifo0_data,
   output logic                fifo0_re,
   input  logic                fifo1_empty,
   input  logic                fifo1_busy,
   input  logic [DATA_W-1:0]   fifo1_data,
   output logic                fifo1_re,
   output logic [DATA_W-1:0]   out_data,
   output logic                out_start,
   input  logic                out_finish,
   output logic                isFinish,
   output logic                grant,
   output logic [CNT_W-1:0]    cnt0,
   output logic [CNT_W-1:0]    cnt1,
   output logic [STATE_W-1:0]  state
);

   state_e              state_q, state_d;
   logic [DATA_W-1:0]   out_data_q, out_data_d;
   logic                out_start_q, out_start_d;
   logic                re0_q, re0_d, re1_q, re1_d;
   logic                is_finish_q, is_finish_d;
   logic                grant_q, grant_d;
   logic [CNT_W-1:0]    cnt0_q, cnt0_d, cnt1_q, cnt1_d;
   logic [1:0]          eligible;
   logic                arb_grant, arb_valid;

   assign eligible = {~fifo1_busy & ~fifo1_empty, ~fifo0_busy & ~fifo0_empty};

   arb_rr2 u_arb (
      .eligible_i   (eligible),
      .last_grant_i (grant_q),
      .next_grant_o (arb_grant),
      .valid_o      (arb_valid)
   );

   // grant resets to 1 so that channel 0 wins the first tie
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         out_data_q  <= '0;
         out_start_q <= 1'b0;
         re0_q       <= 1'b0;
         re1_q       <= 1'b0;
         is_finish_q <= 1'b1;
         grant_q     <= 1'b1;
         cnt0_q      <= '0;
         cnt1_q      <= '0;
      end else if (enable) begin
         state_q     <= state_d;
         out_data_q  <= out_data_d;
         out_start_q <= out_start_d;
         re0_q       <= re0_d;
         re1_q       <= re1_d;
         is_finish_q <= is_finish_d;
         grant_q     <= grant_d;
         cnt0_q      <= cnt0_d;
         cnt1_q      <= cnt1_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      out_data_d  = out_data_q;
      out_start_d = out_start_q;
      re0_d       = re0_q;
      re1_d       = re1_q;
      is_finish_d = is_finish_q;
      grant_d     = grant_q;
      cnt0_d      = cnt0_q;
      cnt1_d      = cnt1_q;
      case (state_q)
         ST_IDLE: begin
            is_finish_d = 1'b1;
            re0_d       = 1'b0;
            re1_d       = 1'b0;
            out_start_d = 1'b0;
            state_d     = ST_ARB;
         end
         ST_ARB: begin
            re0_d = 1'b0;
            re1_d = 1'b0;
            if (out_finish && arb_valid) begin
               grant_d     = arb_grant;
               is_finish_d = 1'b0;
               state_d     = ST_READ;
               if (arb_grant) begin
                  out_data_d = fifo1_data;
                  re1_d      = 1'b1;
               end else begin
                  out_data_d = fifo0_data;
                  re0_d      = 1'b1;
               end
            end
         end
         ST_READ: begin
            re0_d       = 1'b0;
            re1_d       = 1'b0;
            out_start_d = 1'b1;
            state_d     = ST_LAUNCH;
         end
         ST_LAUNCH: begin
            out_start_d = 1'b1;
            if (!out_finish) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (out_finish) begin
               out_start_d = 1'b0;
               is_finish_d = 1'b1;
               state_d     = ST_ARB;
               if (grant_q) cnt1_d = cnt1_q + 16'd1;
               else         cnt0_d = cnt0_q + 16'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign fifo0_re  = re0_q;
   assign fifo1_re  = re1_q;
   assign out_data  = out_data_q;
   assign out_start = out_start_q;
   assign isFinish  = is_finish_q;
   assign grant     = grant_q;
   assign cnt0      = cnt0_q;
   assign cnt1      = cnt1_q;
   assign state     = state_q;

endmodule

// File: tb/tb_fifo_out_arb.sv
// tb/tb_fifo_out_arb.sv - directed self-checking bench for fifo_out_arb
module tb_fifo_out_arb;
   logic        clk = 1'b0;
   logic        reset, enable, out_finish;
   logic        fifo0_empty, fifo0_busy, fifo1_empty, fifo1_busy;
   logic [7:0]  fifo0_data, fifo1_data, out_data;
   logic        fifo0_re, fifo1_re, out_start, isFinish, grant;
   logic [15:0] cnt0, cnt1;
   logic [2:0]  state;

   int          checks = 0;
   int          errors = 0;
   logic [7:0]  q0[$];
   logic [7:0]  q1[$];
   int          order[$];
   bit          auto_tx = 1'b0;
   int          tx_st = 0;

   fifo_out_arb dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .fifo0_empty (fifo0_empty),
      .fifo0_busy  (fifo0_busy),
      .fifo0_data  (fifo0_data),
      .fifo0_re    (fifo0_re),
      .fifo1_empty (fifo1_empty),
      .fifo1_busy  (fifo1_busy),
      .fifo1_data  (fifo1_data),
      .fifo1_re    (fifo1_re),
      .out_data    (out_data),
      .out_start   (out_start),
      .out_finish  (out_finish),
      .isFinish    (isFinish),
      .grant       (grant),
      .cnt0        (cnt0),
      .cnt1        (cnt1),
      .state       (state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic sync_fifos();
      fifo0_empty = (q0.size() == 0);
      fifo0_data  = (q0.size() != 0) ? q0[0] : 8'h00;
      fifo1_empty = (q1.size() == 0);
      fifo1_data  = (q1.size() != 0) ? q1[0] : 8'h00;
   endtask

   // one clock; FIFOs pop on a sampled strobe, transmitter answers out_start low-then-high
   task automatic step();
      logic r0, r1;
      logic [7:0] tmp;
      r0 = fifo0_re;
      r1 = fifo1_re;
      @(posedge clk);
      if (r0 && q0.size() != 0) begin tmp = q0.pop_front(); order.push_back(0); end
      if (r1 && q1.size() != 0) begin tmp = q1.pop_front(); order.push_back(1); end
      #1;
      sync_fifos();
      if (auto_tx) begin
         if (tx_st == 0 && out_start) begin out_finish = 1'b0; tx_st = 1; end
         else if (tx_st == 1) begin out_finish = 1'b1; tx_st = 2; end
         else if (tx_st == 2 && !out_start) tx_st = 0;
      end
   endtask

   initial begin
      int n;
      bit done;
      int exp_order[6];
`ifdef FIFO_OUT_ARB_STRICT_PRIO_EN
      exp_order = '{0, 0, 0, 1, 1, 1};
`else
      exp_order = '{0, 1, 0, 1, 0, 1};
`endif
      reset = 1'b1; enable = 1'b0; out_finish = 1'b1;
      fifo0_busy = 1'b0; fifo1_busy = 1'b0;
      sync_fifos();
      step(); step();
      check("rst_state", state, 0);
      check("rst_start", out_start, 0);
      check("rst_re", {fifo1_re, fifo0_re}, 0);
      check("rst_data", out_data, 0);
      check("rst_isfinish", isFinish, 1);
      check("rst_grant", grant, 1);
      check("rst_cnt", {cnt1, cnt0}, 0);

      // single byte on channel 0, transmitter driven by hand
      reset = 1'b0; enable = 1'b1;
      q0.push_back(8'hA5); sync_fifos();
      step(); check("a_arb", state, 1);
      step();
      check("a_read_state", state, 2);
      check("a_re", {fifo1_re, fifo0_re}, 2'b01);
      check("a_data", out_data, 8'hA5);
      check("a_grant", grant, 0);
      check("a_isfinish", isFinish, 0);
      check("a_start_lo", out_start, 0);
      step();
      check("a_launch", state, 3);
      check("a_re_drop", {fifo1_re, fifo0_re}, 0);
      check("a_start_hi", out_start, 1);
      step(); check("a_launch_hold", state, 3);
      out_finish = 1'b0;
      step(); check("a_wait", state, 4); check("a_wait_start", out_start, 1);
      step(); check("a_wait_hold", state, 4);
      out_finish = 1'b1;
      step();
      check("a_back_arb", state, 1);
      check("a_start_off", out_start, 0);
      check("a_cnt0", cnt0, 1);
      check("a_isfinish_end", isFinish, 1);

      // busy channel is not eligible
      q0.push_back(8'h3C); fifo0_busy = 1'b1; sync_fifos();
      for (int i = 0; i < 3; i++) begin
         step();
         check("b_hold_state", state, 1);
         check("b_hold_re", {fifo1_re, fifo0_re}, 0);
      end
      fifo0_busy = 1'b0;
      step();
      check("b_read", state, 2);
      check("b_re", {fifo1_re, fifo0_re}, 2'b01);
      check("b_grant", grant, 0);
      check("b_data", out_data, 8'h3C);
      auto_tx = 1'b1; tx_st = 0; done = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
         step();
         if (state == 3'd1) done = 1'b1;
      end
      check("b_done", done, 1);
      check("b_cnt0", cnt0, 2);
      auto_tx = 1'b0;

      // enable low while in LAUNCH freezes everything
      q1.push_back(8'h77); sync_fifos();
      step();
      check("c_grant", grant, 1);
      check("c_re", {fifo1_re, fifo0_re}, 2'b10);
      check("c_data", out_data, 8'h77);
      step(); check("c_launch", state, 3);
      enable = 1'b0; out_finish = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         check("c_frz_state", state, 3);
         check("c_frz_start", out_start, 1);
         check("c_frz_re", {fifo1_re, fifo0_re}, 0);
      end
      enable = 1'b1;
      step(); check("c_wait", state, 4);
      out_finish = 1'b1;
      step();
      check("c_arb", state, 1);
      check("c_cnt1", cnt1, 1);
      check("c_cnt0", cnt0, 2);

      // reset while in WAIT aborts without counting
      reset = 1'b1; step(); reset = 1'b0;
      q0.push_back(8'h11); sync_fifos();
      step(); step(); step();
      out_finish = 1'b0;
      step(); check("d_wait", state, 4);
      reset = 1'b1; out_finish = 1'b1;
      step();
      check("d_state", state, 0);
      check("d_start", out_start, 0);
      check("d_cnt", {cnt1, cnt0}, 0);
      check("d_isfinish", isFinish, 1);

      // three bytes per channel, back-to-back at minimum cost
      order.delete();
      q0.push_back(8'h10); q0.push_back(8'h11); q0.push_back(8'h12);
      q1.push_back(8'h20); q1.push_back(8'h21); q1.push_back(8'h22);
      sync_fifos();
      reset = 1'b0; auto_tx = 1'b1; tx_st = 0; n = 0; done = 1'b0;
      for (int i = 0; i < 60 && !done; i++) begin
         step();
         n++;
         if (state == 3'd1 && (cnt0 + cnt1) == 16'd6) done = 1'b1;
      end
      check("e_done", done, 1);
      check("e_cycles", n, 25);
      check("e_cnt0", cnt0, 3);
      check("e_cnt1", cnt1, 3);
      check("e_order_len", order.size(), 6);
      for (int i = 0; i < 6; i++)
         check("e_order", (i < order.size()) ? order[i] : 9, exp_order[i]);
      check("e_last_data", out_data, (exp_order[5] == 1) ? 8'h22 : 8'h12);

      // counter wrap from 0xFFFF
      auto_tx = 1'b0;
      reset = 1'b1; enable = 1'b0; step(); reset = 1'b0;
      force dut.cnt0_q = 16'hFFFF;
      step();
      release dut.cnt0_q;
      step();
      check("f_preload", cnt0, 16'hFFFF);
      enable = 1'b1; q0.push_back(8'h5A); sync_fifos();
      auto_tx = 1'b1; tx_st = 0; done = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
         step();
         if (state == 3'd1 && cnt0 != 16'hFFFF) done = 1'b1;
      end
      check("f_done", done, 1);
      check("f_wrap", cnt0, 16'h0000);
      check("f_cnt1", cnt1, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
